// File: rtl/muldiv_unit_if.sv
// EX-stage multiply/divide port bundle: operation request from ID/EX, HI/LO and busy back.
// The pipeline side holds the master modport; the unit holds the slave modport.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       mdopE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             md_busy;

  modport master (
    output mdopE,
    output srcaE,
    output srcbE,
    input  hi,
    input  lo,
    input  md_busy
  );

  modport slave (
    input  mdopE,
    input  srcaE,
    input  srcbE,
    output hi,
    output lo,
    output md_busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO; mul/div result visible 34 cycles after issue.
// No backpressure: md_busy (RUN/FIX) stalls the pipeline, and any op presented while busy is dropped.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  muldiv_unit_if.slave   md
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               isDiv;
  logic               isSigned;
  logic               negA;
  logic               negB;
  logic               divZero;
  logic [WIDTH-1:0]   rawA;
  logic [WIDTH-1:0]   opA;
  logic [WIDTH-1:0]   opB;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;

  logic               startSigned;
  logic               startDiv;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     remShift;
  logic [WIDTH-1:0]   remDiff;
  logic               remGe;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;

  always_comb begin
    startSigned = (md.mdopE == OP_MULT) || (md.mdopE == OP_DIV);
    startDiv    = (md.mdopE == OP_DIV)  || (md.mdopE == OP_DIVU);
    absA = (startSigned && md.srcaE[WIDTH-1]) ? (~md.srcaE + 1'b1) : md.srcaE;
    absB = (startSigned && md.srcbE[WIDTH-1]) ? (~md.srcbE + 1'b1) : md.srcbE;

    // Multiply step: add multiplicand into the upper half on multiplier LSB, then shift right.
    mulSum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opA} : '0);

    // Restoring divide step; the low WIDTH bits of the difference are exact whenever remGe.
    remShift = {rem, quot[WIDTH-1]};
    remGe    = (remShift >= {1'b0, opB});
    remDiff  = remShift[WIDTH-1:0] - opB;

    prodFix = (isSigned && (negA ^ negB)) ? (~prod + 1'b1) : prod;
    quotFix = (isSigned && (negA ^ negB)) ? (~quot + 1'b1) : quot;
    remFix  = (isSigned && negA) ? (~rem + 1'b1) : rem;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      isDiv    <= 1'b0;
      isSigned <= 1'b0;
      negA     <= 1'b0;
      negB     <= 1'b0;
      divZero  <= 1'b0;
      rawA     <= '0;
      opA      <= '0;
      opB      <= '0;
      prod     <= '0;
      rem      <= '0;
      quot     <= '0;
      hiReg    <= '0;
      loReg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          case (md.mdopE)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              isDiv    <= startDiv;
              isSigned <= startSigned;
              negA     <= startSigned && md.srcaE[WIDTH-1];
              negB     <= startSigned && md.srcbE[WIDTH-1];
              divZero  <= startDiv && (md.srcbE == '0);
              rawA     <= md.srcaE;
              opA      <= absA;
              opB      <= absB;
              prod     <= {{WIDTH{1'b0}}, absB};
              rem      <= '0;
              quot     <= absA;
              count    <= '0;
              state    <= RUN;
            end
            OP_MTHI: hiReg <= md.srcaE;
            OP_MTLO: loReg <= md.srcaE;
            default: ;
          endcase
        end
        RUN: begin
          if (isDiv) begin
            rem  <= remGe ? remDiff : remShift[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], remGe};
          end else begin
            prod <= {mulSum, prod[WIDTH-1:1]};
          end
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (!isDiv) begin
            {hiReg, loReg} <= prodFix;
          end else if (divZero) begin
            // Divide by zero reports the raw dividend, with no sign correction.
            hiReg <= rawA;
            loReg <= '1;
          end else begin
            hiReg <= remFix;
            loReg <= quotFix;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md.hi      = hiReg;
  assign md.lo      = loReg;
  assign md.md_busy = (state == RUN) || (state == FIX);

  logic unusedOp;
  assign unusedOp = (md.mdopE == OP_NONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: fixed vectors with hand-computed HI/LO and busy timing.
module tb_muldiv_unit;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  muldiv_unit_if #(.WIDTH(32)) mdIf ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue op in the current cycle N (called at a falling edge); checks busy N+1..N+33,
  // unchanged HI/LO at N+33, and the result with busy low at N+34.
  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] prevHi, input logic [31:0] prevLo,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    mdIf.mdopE = op;
    mdIf.srcaE = a;
    mdIf.srcbE = b;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 1) mdIf.mdopE = 3'd0;
      chk($sformatf("%s_busy_c%0d", tag, k), {31'd0, mdIf.md_busy}, 32'd1);
    end
    chk({tag, "_hold_hi"}, mdIf.hi, prevHi);
    chk({tag, "_hold_lo"}, mdIf.lo, prevLo);
    @(negedge clk);
    chk({tag, "_idle"}, {31'd0, mdIf.md_busy}, 32'd0);
    chk({tag, "_hi"}, mdIf.hi, expHi);
    chk({tag, "_lo"}, mdIf.lo, expLo);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    mdIf.mdopE = 3'd0;
    mdIf.srcaE = 32'd0;
    mdIf.srcbE = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_hi", mdIf.hi, 32'd0);
    chk("rst_lo", mdIf.lo, 32'd0);
    chk("rst_busy", {31'd0, mdIf.md_busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    runOp("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001);
    runOp("mult_neg", 3'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFEB);
    runOp("mult_min", 3'd1, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'h40000000, 32'h0);
    runOp("div_negA", 3'd3, 32'hFFFFFFF9, 32'd2, 32'h40000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("div_negB", 3'd3, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFD);
    runOp("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFD, 32'h0, 32'h80000000);
    runOp("divu", 3'd4, 32'd100, 32'd7, 32'h0, 32'h80000000, 32'd2, 32'd14);
    runOp("divu_z", 3'd4, 32'h12345678, 32'd0, 32'd2, 32'd14, 32'h12345678, 32'hFFFFFFFF);
    runOp("div_z", 3'd3, 32'hFFFFFFF9, 32'd0, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF);

    // Reserved op behaves as NONE.
    mdIf.mdopE = 3'd7;
    mdIf.srcaE = 32'h01234567;
    @(negedge clk);
    mdIf.mdopE = 3'd0;
    chk("rsvd_busy", {31'd0, mdIf.md_busy}, 32'd0);
    chk("rsvd_hi", mdIf.hi, 32'hFFFFFFF9);
    chk("rsvd_lo", mdIf.lo, 32'hFFFFFFFF);

    mdIf.mdopE = 3'd5;
    mdIf.srcaE = 32'hAAAA5555;
    @(negedge clk);
    mdIf.mdopE = 3'd0;
    chk("mthi_hi", mdIf.hi, 32'hAAAA5555);
    chk("mthi_lo", mdIf.lo, 32'hFFFFFFFF);
    chk("mthi_busy", {31'd0, mdIf.md_busy}, 32'd0);

    mdIf.mdopE = 3'd6;
    mdIf.srcaE = 32'h11111111;
    @(negedge clk);
    mdIf.mdopE = 3'd0;
    chk("mtlo_lo", mdIf.lo, 32'h11111111);
    chk("mtlo_hi", mdIf.hi, 32'hAAAA5555);

    // MTLO/MTHI presented while busy must be dropped.
    mdIf.mdopE = 3'd2;
    mdIf.srcaE = 32'd2;
    mdIf.srcbE = 32'd3;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 1) begin
        mdIf.mdopE = 3'd6;
        mdIf.srcaE = 32'hDEADBEEF;
      end
      if (k == 3) mdIf.mdopE = 3'd5;
      if (k == 5) mdIf.mdopE = 3'd0;
      if (k == 2 || k == 4 || k == 33) begin
        chk($sformatf("ign_hi_c%0d", k), mdIf.hi, 32'hAAAA5555);
        chk($sformatf("ign_lo_c%0d", k), mdIf.lo, 32'h11111111);
        chk($sformatf("ign_busy_c%0d", k), {31'd0, mdIf.md_busy}, 32'd1);
      end
    end
    @(negedge clk);
    chk("ign_hi", mdIf.hi, 32'h0);
    chk("ign_lo", mdIf.lo, 32'd6);
    chk("ign_busy", {31'd0, mdIf.md_busy}, 32'd0);

    // Reset in the middle of a divide aborts it and clears HI/LO at once.
    mdIf.mdopE = 3'd3;
    mdIf.srcaE = 32'd50;
    mdIf.srcbE = 32'd5;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) mdIf.mdopE = 3'd0;
    end
    chk("abort_busy_pre", {31'd0, mdIf.md_busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_hi", mdIf.hi, 32'h0);
    chk("abort_lo", mdIf.lo, 32'h0);
    chk("abort_busy", {31'd0, mdIf.md_busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    runOp("post_rst", 3'd2, 32'd4, 32'd4, 32'h0, 32'h0, 32'h0, 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
